gtx_rx_sync: RTL

GTX_RX_SYNC -- requirements
Module: gtx_rx_sync

---
 rtl/gtx_rx_sync.sv | 106 ++++++++++
 1 files changed

// File: rtl/gtx_rx_sync.sv
// gtx_rx_sync: 8b10b code-group synchronisation FSM with comma-align control and loss-of-sync counting.
module gtx_rx_sync #(
    parameter int LOS_CNT_WIDTH = 16
) (
    input  logic                     RXUSRCLK2_IN,
    input  logic                     RESET_IN,
    input  logic                     RESETDONE_IN,
    input  logic [7:0]               RXDATA_IN,
    input  logic                     RXCHARISK_IN,
    input  logic                     RXCHARISCOMMA_IN,
    input  logic                     RXDISPERR_IN,
    input  logic                     RXNOTINTABLE_IN,
    input  logic [2:0]               RXBUFSTATUS_IN,
    output logic                     ENPCOMMAALIGN_OUT,
    output logic                     ENMCOMMAALIGN_OUT,
    output logic                     SYNC_STATUS_OUT,
    output logic [7:0]               RXDATA_OUT,
    output logic                     RXCHARISK_OUT,
    output logic                     RXEVEN_OUT,
    output logic [LOS_CNT_WIDTH-1:0] LOS_COUNT_OUT,
    output logic [3:0]               STATE_OUT
);
    typedef enum logic [3:0] {
        LOSS_OF_SYNC    = 4'd0,
        COMMA_DETECT_1  = 4'd1,
        ACQUIRE_SYNC_1  = 4'd2,
        COMMA_DETECT_2  = 4'd3,
        ACQUIRE_SYNC_2  = 4'd4,
        COMMA_DETECT_3  = 4'd5,
        SYNC_ACQUIRED_1 = 4'd6,
        SYNC_ACQUIRED_2 = 4'd7,
        SYNC_ACQUIRED_3 = 4'd8,
        SYNC_ACQUIRED_4 = 4'd9
    } state_t;
    state_t     state, nxt;
    logic [1:0] good_cgs, good_nxt;
    logic       even, cur_even, comma, d_char, cgbad, sync_nxt, unused_buf;
    assign comma      = RXCHARISCOMMA_IN;
    assign unused_buf = ^RXBUFSTATUS_IN[1:0];
    // A comma seen while unsynchronised defines an even code-group boundary.
    assign cur_even   = (state == LOSS_OF_SYNC && comma) ? 1'b1 : !even;
    assign d_char     = !RXCHARISK_IN && !RXNOTINTABLE_IN && !RXDISPERR_IN;
    assign cgbad      = RXNOTINTABLE_IN || RXDISPERR_IN || (comma && !cur_even);
    assign sync_nxt   = nxt >= SYNC_ACQUIRED_1;
    assign STATE_OUT  = state;
    always_comb begin
        nxt      = state;
        good_nxt = good_cgs;
        case (state)
            LOSS_OF_SYNC:   nxt = comma ? COMMA_DETECT_1 : LOSS_OF_SYNC;
            COMMA_DETECT_1: nxt = d_char ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            COMMA_DETECT_2: nxt = d_char ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            COMMA_DETECT_3: nxt = d_char ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: nxt = cgbad ? LOSS_OF_SYNC : (comma && cur_even) ? COMMA_DETECT_2 : ACQUIRE_SYNC_1;
            ACQUIRE_SYNC_2: nxt = cgbad ? LOSS_OF_SYNC : (comma && cur_even) ? COMMA_DETECT_3 : ACQUIRE_SYNC_2;
            SYNC_ACQUIRED_1: begin
                nxt      = cgbad ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
                good_nxt = cgbad ? 2'd0 : good_cgs;
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                if (cgbad) begin
                    nxt      = (state == SYNC_ACQUIRED_2) ? SYNC_ACQUIRED_3 :
                               (state == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_4 : LOSS_OF_SYNC;
                    good_nxt = 2'd0;
                end else if (good_cgs == 2'd3) begin
                    nxt      = (state == SYNC_ACQUIRED_4) ? SYNC_ACQUIRED_3 :
                               (state == SYNC_ACQUIRED_3) ? SYNC_ACQUIRED_2 : SYNC_ACQUIRED_1;
                    good_nxt = 2'd0;
                end else begin
                    good_nxt = good_cgs + 2'd1;
                end
            end
            default: nxt = LOSS_OF_SYNC;
        endcase
        if (!RESETDONE_IN || RXBUFSTATUS_IN[2]) begin
            nxt      = LOSS_OF_SYNC;
            good_nxt = 2'd0;
        end
    end
    always_ff @(posedge RXUSRCLK2_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state             <= LOSS_OF_SYNC;
            good_cgs          <= 2'd0;
            even              <= 1'b0;
            SYNC_STATUS_OUT   <= 1'b0;
            ENPCOMMAALIGN_OUT <= 1'b1;
            ENMCOMMAALIGN_OUT <= 1'b1;
            RXDATA_OUT        <= 8'h00;
            RXCHARISK_OUT     <= 1'b0;
            RXEVEN_OUT        <= 1'b0;
            LOS_COUNT_OUT     <= '0;
        end else begin
            state             <= nxt;
            good_cgs          <= good_nxt;
            even              <= cur_even;
            SYNC_STATUS_OUT   <= sync_nxt;
            ENPCOMMAALIGN_OUT <= nxt == LOSS_OF_SYNC;
            ENMCOMMAALIGN_OUT <= nxt == LOSS_OF_SYNC;
            RXDATA_OUT        <= RXDATA_IN;
            RXCHARISK_OUT     <= RXCHARISK_IN;
            RXEVEN_OUT        <= cur_even;
            if (SYNC_STATUS_OUT && !sync_nxt && !(&LOS_COUNT_OUT))
                LOS_COUNT_OUT <= LOS_COUNT_OUT + 1'b1;
        end
    end
endmodule
